arm_immediate_encoder: RTL and testbench

- Inverse of the data-processing immediate decode (32-bit value = imm8 rotated right by 2*rotate).
- Takes a 32-bit constant and searches for a 12-bit shifter operand {rotate[3:0], imm8[7:0]} that reproduces it, optionally via the bitwise-inverted (MVN-style) form.
- Iterative, one rotation per cycle, with a start/done handshake.
- Used by the instruction-memory loader / test-program generator to build immediate-form instructions. It sits outside the core datapath.

---
 rtl/arm_immediate_encoder.sv | 111 +++++++++++
 tb/tb_arm_immediate_encoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/arm_immediate_encoder.sv
// Searches for an ARM data-processing immediate {rotate, imm8} that reproduces a 32-bit constant.
// One rotation tried per cycle; optional inverted (MVN) form; start/done handshake.
module arm_immediate_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        allowInvert,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        inverted,
  output logic [11:0] shiftOperand
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } stateT;

  stateT       state, stateNext;
  logic [3:0]  rotCnt, rotCntNext;
  logic [31:0] latchedValue, latchedValueNext;
  logic        latchedInv, latchedInvNext;
  logic        foundQ, foundNext;
  logic        invQ, invNext;
  logic [11:0] soQ, soNext;

  logic [5:0]  shAmt;
  logic [31:0] candP, candN;
  logic        hitP, hitN;

  // Rotating left by 2*rotCnt undoes a right rotation of the same amount.
  // Inverting commutes with rotation, so the MVN candidate is just ~candP.
  assign shAmt = {1'b0, rotCnt, 1'b0};
  assign candP = (latchedValue << shAmt) | (latchedValue >> (6'd32 - shAmt));
  assign candN = ~candP;
  assign hitP  = (candP[31:8] == 24'd0);
  assign hitN  = latchedInv && (candN[31:8] == 24'd0);

  always_comb begin
    stateNext        = state;
    rotCntNext       = rotCnt;
    latchedValueNext = latchedValue;
    latchedInvNext   = latchedInv;
    foundNext        = foundQ;
    invNext          = invQ;
    soNext           = soQ;
    case (state)
      IDLE: begin
        if (start) begin
          latchedValueNext = value;
          latchedInvNext   = allowInvert;
          foundNext        = 1'b0;
          invNext          = 1'b0;
          soNext           = 12'd0;
          rotCntNext       = 4'd0;
          stateNext        = SEARCH;
        end
      end
      SEARCH: begin
        if (hitP) begin
          foundNext = 1'b1;
          invNext   = 1'b0;
          soNext    = {rotCnt, candP[7:0]};
          stateNext = DONE;
        end else if (hitN) begin
          foundNext = 1'b1;
          invNext   = 1'b1;
          soNext    = {rotCnt, candN[7:0]};
          stateNext = DONE;
        end else if (rotCnt == 4'd15) begin
          foundNext = 1'b0;
          stateNext = DONE;
        end else begin
          rotCntNext = rotCnt + 4'd1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rotCnt       <= 4'd0;
      latchedValue <= 32'd0;
      latchedInv   <= 1'b0;
      foundQ       <= 1'b0;
      invQ         <= 1'b0;
      soQ          <= 12'd0;
    end else begin
      state        <= stateNext;
      rotCnt       <= rotCntNext;
      latchedValue <= latchedValueNext;
      latchedInv   <= latchedInvNext;
      foundQ       <= foundNext;
      invQ         <= invNext;
      soQ          <= soNext;
    end
  end

  assign busy         = (state == SEARCH);
  assign done         = (state == DONE);
  assign found        = foundQ;
  assign inverted     = invQ;
  assign shiftOperand = soQ;

endmodule

// File: tb/tb_arm_immediate_encoder.sv
// Bench for arm_immediate_encoder: brute-force encoding model plus per-cycle output comparison.
module tb_arm_immediate_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        allowInvert;
  logic        busy, done, found, inverted;
  logic [11:0] shiftOperand;

  arm_immediate_encoder dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .allowInvert(allowInvert),
    .busy(busy), .done(done), .found(found), .inverted(inverted), .shiftOperand(shiftOperand)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  // Expected-result state for the transaction in flight (or last completed).
  bit          txValid = 1'b0;
  int          txN     = 0;
  int          expK    = 0;
  logic        expF    = 1'b0;
  logic        expI    = 1'b0;
  logic [11:0] expSo   = 12'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    logic [63:0] t;
    t = {x, x} >> s;
    return t[31:0];
  endfunction

  // Exhaustive search over every decodable immediate; the winning rotation sets the latency.
  task automatic model(input logic [31:0] v, input logic inv, output logic f, output logic i,
                       output logic [11:0] so, output int k);
    f = 1'b0; i = 1'b0; so = 12'd0; k = 15;
    for (int r = 0; r < 16 && !f; r++) begin
      for (int m = 0; m < 256; m++)
        if (!f && ror32(32'(m), 2 * r) == v) begin
          f = 1'b1; i = 1'b0; so = 12'(r * 256 + m); k = r;
        end
      if (inv)
        for (int m = 0; m < 256; m++)
          if (!f && ror32(32'(m), 2 * r) == ~v) begin
            f = 1'b1; i = 1'b1; so = 12'(r * 256 + m); k = r;
          end
    end
  endtask

  // Per-cycle comparison against the model timeline.
  initial begin
    forever begin
      logic        eBusy, eDone, eF, eI;
      logic [11:0] eSo;
      @(posedge clk);
      #1;
      eBusy = 1'b0; eDone = 1'b0; eF = 1'b0; eI = 1'b0; eSo = 12'd0;
      if (txValid) begin
        eBusy = (cyc >= txN + 1) && (cyc <= txN + 1 + expK);
        eDone = (cyc == txN + 2 + expK);
        if (cyc >= txN + 2 + expK) begin
          eF = expF; eI = expI; eSo = expSo;
        end
      end
      check("busy", 32'(busy), 32'(eBusy));
      check("done", 32'(done), 32'(eDone));
      check("found", 32'(found), 32'(eF));
      check("inverted", 32'(inverted), 32'(eI));
      check("shiftOperand", 32'(shiftOperand), 32'(eSo));
    end
  end

  task automatic runTxn(input logic [31:0] v, input logic inv, input bit hasTable,
                        input logic [11:0] tSo, input logic tF, input logic tI, input int tK,
                        input bit injectIgnored);
    logic        f, i;
    logic [11:0] so;
    int          k;
    bit          seen;
    int          doneCyc;
    @(negedge clk);
    model(v, inv, f, i, so, k);
    if (hasTable) begin
      check("model_so", 32'(so), 32'(tSo));
      check("model_found", 32'(f), 32'(tF));
      check("model_inv", 32'(i), 32'(tI));
      check("model_rot", k, tK);
    end
    expF = f; expI = i; expSo = so; expK = k;
    txN = cyc; txValid = 1'b1;
    start = 1'b1; value = v; allowInvert = inv;
    @(negedge clk);
    start = 1'b0; value = $urandom; allowInvert = 1'($urandom_range(0, 1));
    if (injectIgnored) begin
      @(negedge clk);
      start = 1'b1; value = 32'h000000FF; allowInvert = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    doneCyc = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (done) begin
        seen = 1'b1;
        doneCyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("done_latency", doneCyc - txN, (hasTable ? tK : k) + 2);
      if (found)
        check("decode_identity", ror32({24'd0, shiftOperand[7:0]}, 2 * int'(shiftOperand[11:8])),
              inverted ? ~v : v);
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  imm;
    rst = 1'b0; start = 1'b0; value = 32'd0; allowInvert = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_so", 32'(shiftOperand), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    runTxn(32'h000000FF, 1'b0, 1'b1, 12'h0FF, 1'b1, 1'b0, 0, 1'b0);
    runTxn(32'hFF000000, 1'b0, 1'b1, 12'h4FF, 1'b1, 1'b0, 4, 1'b0);
    runTxn(32'h00000104, 1'b0, 1'b1, 12'hF41, 1'b1, 1'b0, 15, 1'b0);
    runTxn(32'hFFFFFF00, 1'b1, 1'b1, 12'h0FF, 1'b1, 1'b1, 0, 1'b0);
    runTxn(32'hFFFFFF00, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 15, 1'b0);
    runTxn(32'h00000101, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 15, 1'b0);
    runTxn(32'h00000000, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0, 0, 1'b0);
    runTxn(32'h000003FC, 1'b0, 1'b1, 12'hFFF, 1'b1, 1'b0, 15, 1'b1);
    runTxn(32'h000000FF, 1'b0, 1'b1, 12'h0FF, 1'b1, 1'b0, 0, 1'b0);

    // Reset in the middle of a missing search.
    @(negedge clk);
    expF = 1'b0; expI = 1'b0; expSo = 12'd0; expK = 15;
    txN = cyc; txValid = 1'b1;
    start = 1'b1; value = 32'h00000101; allowInvert = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b0; txValid = 1'b0;
    #1;
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_done", 32'(done), 32'd0);
    check("mid_reset_found", 32'(found), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    runTxn(32'hFF000000, 1'b0, 1'b1, 12'h4FF, 1'b1, 1'b0, 4, 1'b0);

    for (int n = 0; n < 2000; n++) begin
      if (n % 2 == 1) begin
        v = $urandom;
      end else begin
        imm = 8'($urandom_range(0, 255));
        v = ror32({24'd0, imm}, 2 * int'($urandom_range(0, 15)));
        if ($urandom_range(0, 1) == 1) v = ~v;
      end
      runTxn(v, 1'($urandom_range(0, 1)), 1'b0, 12'd0, 1'b0, 1'b0, 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
